da_shift_accumulator_z3: RTL

//  Bit-serial distributed-arithmetic (DA) engine that drives the Z3 half-size coefficient ROM.
//  It consumes one 4-sample butterfly vector, walks its bit-planes MSB first and generates
//  the ROM address for each plane. It shift-accumulates the returned 16-bit partial sums

---
 rtl/da_shift_accumulator_z3.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/da_shift_accumulator_z3.sv
// Bit-serial distributed-arithmetic engine for the Z3 coefficient ROM: walks the
// bit-planes of a 4-sample vector MSB first and shift-accumulates the ROM partial sums.
module da_shift_accumulator_z3 #(
    parameter  int IN_W       = 8,
    parameter  int ROM_W      = 16,
    parameter  int OBC_OFFSET = 0,
    localparam int ACC_W      = ROM_W + 1 + IN_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  x0,
    input  logic signed [IN_W-1:0]  x1,
    input  logic signed [IN_W-1:0]  x2,
    input  logic signed [IN_W-1:0]  x3,
    output logic                    rom_cs,
    output logic [2:0]              rom_addr,
    input  logic signed [ROM_W-1:0] rom_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data
);

    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_init_done;
    logic signed [IN_W-1:0]  r_x0;
    logic signed [IN_W-1:0]  r_x1;
    logic signed [IN_W-1:0]  r_x2;
    logic signed [IN_W-1:0]  r_x3;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_out_data;
    logic                    r_out_valid;

    logic                    w_b0;
    logic                    w_b1;
    logic                    w_b2;
    logic                    w_b3;
    logic                    w_accept;
    logic                    w_first;
    logic                    w_last;
    logic signed [ROM_W:0]   w_rom_ext;
    logic signed [ROM_W:0]   w_t;
    logic signed [ACC_W-1:0] w_t_ext;
    logic signed [ACC_W-1:0] w_acc_nxt;

    assign w_b0 = r_x0[r_cnt];
    assign w_b1 = r_x1[r_cnt];
    assign w_b2 = r_x2[r_cnt];
    assign w_b3 = r_x3[r_cnt];

    assign w_first = (r_cnt == CNT_W'(IN_W - 1));
    assign w_last  = (r_cnt == '0);

    // One extra bit so that negating the most negative ROM word stays exact.
    assign w_rom_ext = {rom_data[ROM_W-1], rom_data};
    assign w_t       = w_b0 ? -w_rom_ext : w_rom_ext;
    assign w_t_ext   = {{(ACC_W-ROM_W-1){w_t[ROM_W]}}, w_t};
    assign w_acc_nxt = w_first ? -w_t_ext : (r_acc <<< 1) + w_t_ext;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        rom_cs      = 1'b0;
        rom_addr    = '0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = r_init_done;
                w_accept = in_valid && in_ready;
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                rom_cs   = 1'b1;
                rom_addr = w_b0 ? ~{w_b1, w_b2, w_b3} : {w_b1, w_b2, w_b3};
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                in_ready = out_ready;
                w_accept = in_valid && in_ready;
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end else if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_done <= 1'b0;
            r_x0        <= '0;
            r_x1        <= '0;
            r_x2        <= '0;
            r_x3        <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_init_done <= 1'b1;
            if (r_state == S_DONE && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_x0  <= x0;
                r_x1  <= x1;
                r_x2  <= x2;
                r_x3  <= x3;
                r_cnt <= CNT_W'(IN_W - 1);
                r_acc <= '0;
            end else if (r_state == S_RUN) begin
                r_acc <= w_acc_nxt;
                if (w_last) begin
                    r_out_data  <= w_acc_nxt + ACC_W'(OBC_OFFSET);
                    r_out_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule
